fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory address. Captures the 32-bit word returned one cycle later.
- Buffers each {pc, instr} pair in a 2-entry queue and presents it to decode with a valid/ready handshake.
- Supports back-pressure from decode and a zero-bubble redirect on branch/jump that flushes all in-flight and buffered work.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC, one-deep memory pipe and 2-entry output queue
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;

    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [CW-1:0]   count_q;

    logic [XLEN-1:0] target;
    logic            deq;
    logic            push;
    logic [CW:0]     occ_after;
    logic            issue;
    logic            unused_redirect_lsbs;

    assign target               = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign out_valid = (count_q != '0);
    assign out_pc    = q_pc[rd_ptr_q];
    assign out_instr = q_instr[rd_ptr_q];

    assign deq  = out_valid & out_ready;
    assign push = inflight_q & ~redirect_valid;

    // Entries that will still be owed to decode after this cycle's handshake;
    // a new read is only issued if its response is guaranteed a queue slot.
    assign occ_after = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(deq);
    assign issue     = ~rst & (occ_after < (CW+1)'(DEPTH));

    always_comb begin
        imem_addr = pc_q;
        if (rst) begin
            imem_addr = RESET_PC;
        end else if (redirect_valid) begin
            imem_addr = target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Old response and queued work are dropped; the target read goes out now.
            pc_q          <= target + XLEN'(4);
            inflight_q    <= 1'b1;
            inflight_pc_q <= target;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            if (issue) begin
                pc_q          <= pc_q + XLEN'(4);
                inflight_q    <= 1'b1;
                inflight_pc_q <= pc_q;
            end else begin
                inflight_q <= 1'b0;
            end
            if (push) begin
                q_pc[wr_ptr_q]    <= inflight_pc_q;
                q_instr[wr_ptr_q] <= imem_rdata;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + CW'(push) - CW'(deq);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a decode-view model
module tb_fetch_unit;

    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] WRPC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc;

    logic [31:0] w_imem_addr, w_imem_rdata;
    logic        w_out_valid;
    logic [31:0] w_out_instr, w_out_pc;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_pc;
    int          age;
    logic [31:0] w_exp;
    int          w_age;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(RPC), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(WRPC), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_instr(w_out_instr), .out_pc(w_out_pc)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        imem_rdata   <= word(imem_addr);
        w_imem_rdata <= word(w_imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Decode's view: once a fetch stream is 2+ cycles old the head is always valid
    // and is the next sequential PC; the fetcher runs exactly two words ahead of it.
    task automatic cyc(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
        if (age < 1000) age++;
        if (w_age < 1000) w_age++;
        if (r) begin
            chk("rst_addr", imem_addr, RPC);
            chk("wrap_rst_addr", w_imem_addr, WRPC);
        end else begin
            if (age == 0) begin
                chk("rst_valid", {31'b0, out_valid}, 32'd0);
                chk("rst_pc", out_pc, 32'd0);
                chk("rst_instr", out_instr, 32'd0);
            end else if (age == 1) begin
                chk("startup_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                chk("valid", {31'b0, out_valid}, 32'd1);
                chk("pc", out_pc, exp_pc);
                chk("instr", out_instr, word(exp_pc));
            end
            if (rv) chk("redir_addr", imem_addr, {rpc[31:2], 2'b00});
            else    chk("addr", imem_addr, exp_pc + ((age >= 2) ? 32'd8 : 32'(age * 4)));
            if (age >= 2 && rdy) exp_pc = exp_pc + 32'd4;
            if (rv) begin
                exp_pc = {rpc[31:2], 2'b00};
                age    = 0;
            end
            if (w_age >= 2) begin
                chk("wrap_valid", {31'b0, w_out_valid}, 32'd1);
                chk("wrap_pc", w_out_pc, w_exp);
                chk("wrap_instr", w_out_instr, word(w_exp));
                w_exp = w_exp + 32'd4;
            end else begin
                chk("wrap_startup_valid", {31'b0, w_out_valid}, 32'd0);
            end
        end
        if (r) begin
            exp_pc = RPC;  age   = -1;
            w_exp  = WRPC; w_age = -1;
        end
        @(negedge clk);
    endtask

    initial begin
        exp_pc = RPC; age = -1; w_exp = WRPC; w_age = -1;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_0103);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h0000_0200);
        cyc(0, 1, 1, 32'h0000_0300);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'hFFFF_FFF4);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(127) == 0), ($urandom_range(3) != 0),
                ($urandom_range(15) == 0), $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
